// File: rtl/hazard_forward_unit_pkg.sv
// Shared types and encodings for the hazard/forwarding controller.
package core_pkg;

   localparam int CORE_AW = 5;

   // Execute operand mux select encodings; 2'b11 is never produced.
   typedef logic [1:0] fwd_sel_t;
   localparam fwd_sel_t FWD_RF  = 2'b00;
   localparam fwd_sel_t FWD_WB  = 2'b01;
   localparam fwd_sel_t FWD_MEM = 2'b10;

   // Full tag of the instruction in Execute.
   typedef struct packed {
      logic [CORE_AW-1:0] rs1;
      logic [CORE_AW-1:0] rs2;
      logic [CORE_AW-1:0] rd;
      logic               regwrite;
      logic               load;
   } stage_tag_t;

   // Memory and Writeback only need the destination side of the tag.
   typedef struct packed {
      logic [CORE_AW-1:0] rd;
      logic               regwrite;
      logic               load;
   } dst_tag_t;

   localparam int NUM_OPS = 2;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Operand forward select for one Execute source: M beats W beats register file.
module fwd_select
   import core_pkg::*;
(
   input  logic [CORE_AW-1:0] src,
   input  dst_tag_t           m,
   input  dst_tag_t           w,
   output fwd_sel_t           sel
);

   // Youngest matching writer wins; x0 is never forwarded.
   always_comb begin
      sel = FWD_RF;
      if (m.regwrite && (m.rd != '0) && (m.rd == src))
         sel = FWD_MEM;
      else if (w.regwrite && (w.rd != '0) && (w.rd == src))
         sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller: shadows E/M/W register tags and derives
// Execute operand selects plus F/D/E stall and flush controls.
module hazard_forward_unit
   import core_pkg::*;
#(
   parameter int REG_AW = CORE_AW,
   parameter int FWD_W  = 2
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rdD,
   input  logic              regwriteD,
   input  logic              loadD,
   input  logic              pcsrcE,
   output logic [FWD_W-1:0]  forwardAE,
   output logic [FWD_W-1:0]  forwardBE,
   output logic              stallF,
   output logic              stallD,
   output logic              flushD,
   output logic              flushE
);

   stage_tag_t e_q;
   dst_tag_t   m_q, w_q;
   logic       lw_stall;

   // Shadow pipeline: advances every cycle, E takes a bubble on flushE.
   always_ff @(posedge clk) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         w_q <= m_q;
         m_q <= '{rd: e_q.rd, regwrite: e_q.regwrite, load: e_q.load};
         if (flushE)
            e_q <= '0;
         else
            e_q <= '{rs1: rs1D, rs2: rs2D, rd: rdD, regwrite: regwriteD, load: loadD};
      end
   end

   // One select unit per Execute operand (A uses rs1, B uses rs2).
   logic     [NUM_OPS-1:0][CORE_AW-1:0] op_src;
   fwd_sel_t [NUM_OPS-1:0]              op_sel;

   assign op_src[0] = e_q.rs1;
   assign op_src[1] = e_q.rs2;

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
      fwd_select u_fwd (
         .src (op_src[g]),
         .m   (m_q),
         .w   (w_q),
         .sel (op_sel[g])
      );
   end

   assign forwardAE = op_sel[0];
   assign forwardBE = op_sel[1];

   // Load-use hazard; a taken branch squashes the Decode consumer instead.
   always_comb begin
      lw_stall = e_q.load && (e_q.rd != '0) &&
                 ((e_q.rd == rs1D) || (e_q.rd == rs2D)) && !pcsrcE;
   end

   assign stallF = lw_stall;
   assign stallD = lw_stall;
   assign flushD = pcsrcE;
   assign flushE = lw_stall | pcsrcE;

   // Load flags in M/W are tracked for completeness but steer nothing.
   logic unused_tags;
   assign unused_tags = &{1'b0, m_q.load, w_q.load};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: instruction sequences with
// hand-computed selects and stall/flush controls.
module tb_hazard_forward_unit;

   logic       clk;
   logic       reset;
   logic [4:0] rs1D, rs2D, rdD;
   logic       regwriteD, loadD, pcsrcE;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, flushD, flushE;

   int n_cmp;
   int n_bad;

   hazard_forward_unit #(.REG_AW(5), .FWD_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .rs1D      (rs1D),
      .rs2D      (rs2D),
      .rdD       (rdD),
      .regwriteD (regwriteD),
      .loadD     (loadD),
      .pcsrcE    (pcsrcE),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE),
      .stallF    (stallF),
      .stallD    (stallD),
      .flushD    (flushD),
      .flushE    (flushE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Put an instruction on the Decode inputs without clocking.
   task automatic drive(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic ld);
      rs1D = r1; rs2D = r2; rdD = rd; regwriteD = rw; loadD = ld;
   endtask

   // Present an instruction in D and clock it into E; sample 1 time unit later.
   task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rw, input logic ld);
      drive(r1, r2, rd, rw, ld);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({forwardAE, forwardBE, stallF, stallD, flushD, flushE} !== 8'b0000_0000) begin
         n_bad++;
         $display("FAIL reset_idle: got fA=%b fB=%b sF=%b sD=%b fD=%b fE=%b want all 0",
                  forwardAE, forwardBE, stallF, stallD, flushD, flushE);
      end
      pcsrcE = 1'b1; #1;
      n_cmp++;
      if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
         n_bad++;
         $display("FAIL reset_branch: got sF=%b sD=%b fD=%b fE=%b want 0011",
                  stallF, stallD, flushD, flushE);
      end
      pcsrcE = 1'b0; #1;
   endtask

   task automatic test_fwd_mem();
      drain();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5,x1,x2
      issue(5'd5, 5'd3, 5'd6, 1'b1, 1'b0);   // add x6,x5,x3 now in E
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b10_00) begin
         n_bad++;
         $display("FAIL fwd_mem: got fA=%b fB=%b want fA=10 fB=00", forwardAE, forwardBE);
      end
   endtask

   task automatic test_fwd_wb();
      drain();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
      issue(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);   // nop
      issue(5'd4, 5'd5, 5'd7, 1'b1, 1'b0);   // sub x7,x4,x5 now in E
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_01) begin
         n_bad++;
         $display("FAIL fwd_wb: got fA=%b fB=%b want fA=00 fB=01", forwardAE, forwardBE);
      end
   endtask

   task automatic test_priority();
      drain();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      issue(5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
      issue(5'd5, 5'd5, 5'd8, 1'b1, 1'b0);   // or x8,x5,x5
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b10_10) begin
         n_bad++;
         $display("FAIL fwd_m_over_w: got fA=%b fB=%b want 10 10", forwardAE, forwardBE);
      end
      drain();
      issue(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      issue(5'd3, 5'd4, 5'd0, 1'b1, 1'b0);
      issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_00) begin
         n_bad++;
         $display("FAIL fwd_x0: got fA=%b fB=%b want 00 00", forwardAE, forwardBE);
      end
      // Writer without regwrite must not forward.
      drain();
      issue(5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
      issue(5'd9, 5'd9, 5'd3, 1'b1, 1'b0);
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_00) begin
         n_bad++;
         $display("FAIL fwd_no_regwrite: got fA=%b fB=%b want 00 00", forwardAE, forwardBE);
      end
   endtask

   task automatic test_load_use();
      drain();
      issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1);   // lw x6 now in E
      drive(5'd1, 5'd6, 5'd7, 1'b1, 1'b0);   // add x7,x1,x6 held in D
      #1;
      n_cmp++;
      if ({stallF, stallD, flushD, flushE} !== 4'b1101) begin
         n_bad++;
         $display("FAIL lw_stall: got sF=%b sD=%b fD=%b fE=%b want 1101",
                  stallF, stallD, flushD, flushE);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({forwardAE, forwardBE, stallF, stallD, flushD, flushE} !== 8'b0000_0000) begin
         n_bad++;
         $display("FAIL lw_bubble: got fA=%b fB=%b sF=%b sD=%b fD=%b fE=%b want all 0",
                  forwardAE, forwardBE, stallF, stallD, flushD, flushE);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_01) begin
         n_bad++;
         $display("FAIL lw_fwd_wb: got fA=%b fB=%b want fA=00 fB=01", forwardAE, forwardBE);
      end
   endtask

   task automatic test_load_branch();
      drain();
      issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1);   // lw x6 in E
      drive(5'd6, 5'd1, 5'd7, 1'b1, 1'b0);
      pcsrcE = 1'b1; #1;
      n_cmp++;
      if ({stallF, stallD, flushD, flushE} !== 4'b0011) begin
         n_bad++;
         $display("FAIL lw_branch: got sF=%b sD=%b fD=%b fE=%b want 0011",
                  stallF, stallD, flushD, flushE);
      end
      @(posedge clk); #1;
      pcsrcE = 1'b0;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      n_cmp++;
      if ({forwardAE, forwardBE, stallF, stallD} !== 6'b0000_00) begin
         n_bad++;
         $display("FAIL lw_branch_bubble: got fA=%b fB=%b sF=%b sD=%b want all 0",
                  forwardAE, forwardBE, stallF, stallD);
      end
   endtask

   task automatic test_reset_mid_stall();
      drain();
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // writer x5
      issue(5'd1, 5'd2, 5'd6, 1'b1, 1'b1);   // lw x6 in E
      drive(5'd5, 5'd6, 5'd9, 1'b1, 1'b0);   // consumer of x5 and x6
      #1;
      n_cmp++;
      if (stallF !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_pre_stall: got sF=%b want 1", stallF);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; #1;
      n_cmp++;
      if ({forwardAE, forwardBE, stallF, stallD, flushE} !== 7'b0000_000) begin
         n_bad++;
         $display("FAIL rst_mid_stall: got fA=%b fB=%b sF=%b sD=%b fE=%b want all 0",
                  forwardAE, forwardBE, stallF, stallD, flushE);
      end
      @(posedge clk); #1;                    // consumer reaches E; M/W are bubbles
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_00) begin
         n_bad++;
         $display("FAIL rst_no_stale_fwd: got fA=%b fB=%b want 00 00", forwardAE, forwardBE);
      end
      // A fresh writer through D is forwarded again.
      issue(5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      issue(5'd3, 5'd5, 5'd4, 1'b1, 1'b0);
      n_cmp++;
      if ({forwardAE, forwardBE} !== 4'b00_10) begin
         n_bad++;
         $display("FAIL rst_refwd: got fA=%b fB=%b want fA=00 fB=10", forwardAE, forwardBE);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      pcsrcE = 1'b0;
      drive(5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0; #1;
      test_reset();
      test_fwd_mem();
      test_fwd_wb();
      test_priority();
      test_load_use();
      test_load_branch();
      test_reset_mid_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
